// File: rtl/speck_decrypt_core.sv
// Iterative SPECK128/128 decryption: expands the key schedule once per start into a
// round-key file, then walks the inverse rounds from the last round key down to rk[0].
module speck_decrypt_core #(
  parameter int unsigned ROUNDS = 32,
  parameter int unsigned ALPHA  = 8,
  parameter int unsigned BETA   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] ciphertext,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CntW = $clog2(ROUNDS);
  localparam logic [CntW-1:0] LastRound = CntW'(ROUNDS - 1);

  typedef enum logic [1:0] {StIdle, StKeygen, StDecrypt, StDone} state_e;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [63:0] rol64(input logic [63:0] v, input int unsigned n);
    return (v << n) | (v >> (64 - n));
  endfunction

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [63:0]      l_q, l_d, k_q, k_d;
  logic [63:0]      x_q, x_d, y_q, y_d;
  logic [127:0]     pt_q, pt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [63:0]      rk_q [ROUNDS];

  logic [63:0]      l_new, x_new, y_new;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    k_d     = k_q;
    x_d     = x_q;
    y_d     = y_q;
    pt_d    = pt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    l_new   = '0;
    x_new   = '0;
    y_new   = '0;

    case (state_q)
      StIdle: begin
        if (start) begin
          l_d     = key[127:64];
          k_d     = key[63:0];
          x_d     = ciphertext[127:64];
          y_d     = ciphertext[63:0];
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StKeygen;
        end
      end
      StKeygen: begin
        // The current k is stored as rk[cnt] in the key-file process below.
        l_new = (k_q + ror64(l_q, ALPHA)) ^ 64'(cnt_q);
        l_d   = l_new;
        k_d   = rol64(k_q, BETA) ^ l_new;
        if (cnt_q == LastRound) begin
          state_d = StDecrypt;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDecrypt: begin
        y_new = ror64(x_q ^ y_q, BETA);
        x_new = rol64((x_q ^ rk_q[cnt_q]) - y_new, ALPHA);
        x_d   = x_new;
        y_d   = y_new;
        if (cnt_q == '0) begin
          pt_d    = {x_new, y_new};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      l_q     <= '0;
      k_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pt_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      k_q     <= k_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pt_q    <= pt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StKeygen) begin
      rk_q[cnt_q] <= k_q;
    end
  end

  assign plaintext = pt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_speck_decrypt_core.sv
// Scoreboard bench for speck_decrypt_core: stimulus pushes expected plaintexts, a monitor
// pops and checks value and latency on every done pulse.
module tb_speck_decrypt_core;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] ciphertext = '0;
  logic [127:0] plaintext;
  logic         busy;
  logic         done;

  speck_decrypt_core dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key        (key),
    .ciphertext (ciphertext),
    .plaintext  (plaintext),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] pt;
    int unsigned  sc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic prev_done = 1'b0;

  localparam logic [127:0] VecKey = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] VecCt  = 128'ha65d985179783265_7860fedf5c570d18;
  localparam logic [127:0] VecPt  = 128'h6c61766975716520_7469206564616d20;

  function automatic void check(input bit ok, input string name,
                                input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [63:0] rol(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  // Reference SPECK128/128 encryption, round keys generated on the fly.
  function automatic logic [127:0] model_encrypt(input logic [127:0] kk, input logic [127:0] p);
    logic [63:0] x = p[127:64], y = p[63:0], l = kk[127:64], k = kk[63:0];
    for (int i = 0; i < 32; i++) begin
      x = (ror(x, 8) + y) ^ k;
      y = rol(y, 3) ^ x;
      l = (k + ror(l, 8)) ^ 64'(i);
      k = rol(k, 3) ^ l;
    end
    return {x, y};
  endfunction

  function automatic logic [127:0] model_decrypt(input logic [127:0] kk, input logic [127:0] c);
    logic [63:0] rks [32];
    logic [63:0] x = c[127:64], y = c[63:0], l = kk[127:64], k = kk[63:0];
    for (int i = 0; i < 32; i++) begin
      rks[i] = k;
      l = (k + ror(l, 8)) ^ 64'(i);
      k = rol(k, 3) ^ l;
    end
    for (int i = 31; i >= 0; i--) begin
      y = ror(x ^ y, 3);
      x = rol((x ^ rks[i]) - y, 8);
    end
    return {x, y};
  endfunction

  // Monitor: every done must match the oldest outstanding expectation, 64 edges after start.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      check(!prev_done, "done_width", 128'(prev_done), 128'(0));
      check(!busy, "busy_at_done", 128'(busy), 128'(0));
      if (sb.size() == 0) begin
        check(1'b0, "unexpected_done", 128'(done), 128'(0));
      end else begin
        e = sb.pop_front();
        check(plaintext === e.pt, "plaintext", plaintext, e.pt);
        check(cyc - e.sc == 64, "latency", 128'(cyc - e.sc), 128'(64));
      end
    end
    prev_done = done;
  end

  task automatic run_op(input logic [127:0] k, input logic [127:0] c, input logic [127:0] exp_pt,
                        input bit disturb, input bit hold_chk, input logic [127:0] hold_val);
    exp_t e;
    int unsigned rel;
    @(negedge clk);
    key = k;
    ciphertext = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.pt = exp_pt;
    e.sc = cyc;
    sb.push_back(e);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      rel = cyc - e.sc;
      start = 1'b0;
      if (rel == 0 || rel == 63) check(busy === 1'b1, "busy_running", 128'(busy), 128'(1));
      if (hold_chk && rel == 30) check(plaintext === hold_val, "plaintext_held", plaintext, hold_val);
      if (disturb && (rel == 10 || rel == 40)) begin
        start = 1'b1;
        key = {$urandom, $urandom, $urandom, $urandom};
        ciphertext = {$urandom, $urandom, $urandom, $urandom};
      end
      if (sb.size() == 0) break;
    end
    start = 1'b0;
    if (sb.size() != 0) begin
      check(1'b0, "timeout", 128'(sb.size()), 128'(0));
      sb.delete();
    end
  endtask

  task automatic abort_op(input int unsigned at);
    @(negedge clk);
    key = VecKey;
    ciphertext = VecCt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (at) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check(busy === 1'b0, "abort_busy", 128'(busy), 128'(0));
    check(done === 1'b0, "abort_done", 128'(done), 128'(0));
    check(plaintext === '0, "abort_plaintext", plaintext, 128'(0));
    repeat (80) @(negedge clk);
    check(plaintext === '0, "abort_plaintext_late", plaintext, 128'(0));
  endtask

  initial begin
    logic [127:0] rk, rp, rc;
    logic [127:0] edge_vals [2];
    edge_vals[0] = '0;
    edge_vals[1] = '1;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check(!$isunknown({plaintext, busy, done}), "no_x_after_reset",
          128'({busy, done}), 128'(0));
    check(busy === 1'b0, "reset_busy", 128'(busy), 128'(0));
    check(done === 1'b0, "reset_done", 128'(done), 128'(0));
    check(plaintext === '0, "reset_plaintext", plaintext, 128'(0));

    run_op(VecKey, VecCt, VecPt, 1'b0, 1'b0, '0);
    repeat (5) @(negedge clk);
    check(plaintext === VecPt, "vector_hold_idle", plaintext, VecPt);

    run_op(VecKey, VecCt, VecPt, 1'b1, 1'b0, '0);
    repeat (3) @(negedge clk);

    abort_op(20);
    abort_op(50);
    run_op(VecKey, VecCt, VecPt, 1'b0, 1'b0, '0);

    // Back-to-back: the next start lands on the first idle cycle after done.
    rk = {$urandom, $urandom, $urandom, $urandom};
    rp = {$urandom, $urandom, $urandom, $urandom};
    run_op(rk, model_encrypt(rk, rp), rp, 1'b0, 1'b1, VecPt);

    for (int n = 0; n < 200; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      rc = model_encrypt(rk, rp);
      run_op(rk, rc, rp, 1'b0, 1'b0, '0);
    end

    for (int a = 0; a < 2; a++) begin
      for (int b = 0; b < 2; b++) begin
        run_op(edge_vals[a], edge_vals[b], model_decrypt(edge_vals[a], edge_vals[b]),
               1'b0, 1'b0, '0);
      end
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
